// File: rtl/eigenportfolio_if.sv
// Request/result bundle for the eigenportfolio block: matrices in, normalized weights out.
interface eigenportfolio_if;
    logic                         start;
    logic signed [2:0][2:0][15:0] eigenvalues;
    logic signed [2:0][2:0][15:0] eigenvectors;
    logic                         done;
    logic signed [2:0][15:0]      portfolio;

    modport master (output start, eigenvalues, eigenvectors, input done, portfolio);
    modport slave  (input start, eigenvalues, eigenvectors, output done, portfolio);
endinterface

// File: rtl/eigenportfolio.sv
// Picks the eigenvector of the middle eigenvalue and normalizes it so its components sum to one,
// using three parallel restoring dividers (Q8.8 in, Q8.8 out with 7 significant fractional bits).
module eigenportfolio (
    input  logic            clk,
    input  logic            rst,
    eigenportfolio_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SELECT, DIVIDE, FINISH} state_t;

    state_t                  state_reg;
    logic signed [15:0]      diag_reg     [3];
    logic signed [15:0]      vec_reg      [3][3];
    logic [22:0]             dividend_reg [3];
    logic [22:0]             quot_reg     [3];
    logic [16:0]             rem_reg      [3];
    logic [16:0]             divisor_reg;
    logic [2:0]              neg_reg;
    logic                    sum_zero_reg;
    logic [4:0]              count_reg;
    logic                    done_reg;
    logic signed [2:0][15:0] port_reg;

    logic [1:0]              above_cnt   [3];
    logic [1:0]              sel_col;
    logic signed [15:0]      vsel        [3];
    logic [15:0]             abs_v       [3];
    logic signed [17:0]      sum_s;
    logic [16:0]             abs_sum;
    logic                    fits        [3];
    logic [16:0]             rem_next    [3];
    logic signed [15:0]      result_word [3];

    // Strict total order: larger value first, equal values broken by lower index first.
    function automatic logic ranks_above(input logic signed [15:0] a, input logic signed [15:0] b,
                                         input int ia, input int ib);
        return (ia != ib) && ((a > b) || ((a == b) && (ia < ib)));
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rank
            assign above_cnt[gi] = 2'(ranks_above(diag_reg[0], diag_reg[gi], 0, gi))
                                 + 2'(ranks_above(diag_reg[1], diag_reg[gi], 1, gi))
                                 + 2'(ranks_above(diag_reg[2], diag_reg[gi], 2, gi));
        end
    endgenerate

    always_comb begin
        sel_col = 2'd0;
        if (above_cnt[1] == 2'd1)
            sel_col = 2'd1;
        else if (above_cnt[2] == 2'd1)
            sel_col = 2'd2;
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [17:0] rem_shift;
            logic [23:0] mag_full;
            logic [15:0] mag_sat;

            assign vsel[gi]  = vec_reg[gi][sel_col];
            assign abs_v[gi] = vsel[gi][15] ? 16'(-vsel[gi]) : 16'(vsel[gi]);

            // One restoring-division step: shift in the next dividend bit, subtract if it fits.
            assign rem_shift    = {rem_reg[gi], dividend_reg[gi][22]};
            assign fits[gi]     = (rem_shift >= {1'b0, divisor_reg});
            assign rem_next[gi] = fits[gi] ? 17'(rem_shift - {1'b0, divisor_reg}) : rem_shift[16:0];

            assign mag_full = {quot_reg[gi], 1'b0};
            assign mag_sat  = (mag_full > 24'h007FFE) ? 16'h7FFE : mag_full[15:0];
            assign result_word[gi] = sum_zero_reg ? 16'sd0
                                   : (neg_reg[gi] ? -$signed(mag_sat) : $signed(mag_sat));
        end
    endgenerate

    assign sum_s   = 18'(vsel[0]) + 18'(vsel[1]) + 18'(vsel[2]);
    assign abs_sum = sum_s[17] ? 17'(-sum_s) : sum_s[16:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            done_reg     <= 1'b0;
            port_reg     <= '0;
            divisor_reg  <= '0;
            neg_reg      <= '0;
            sum_zero_reg <= 1'b0;
            count_reg    <= '0;
            for (int i = 0; i < 3; i++) begin
                diag_reg[i]     <= '0;
                dividend_reg[i] <= '0;
                quot_reg[i]     <= '0;
                rem_reg[i]      <= '0;
                for (int j = 0; j < 3; j++)
                    vec_reg[i][j] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 3; i++) begin
                            diag_reg[i] <= $signed(bus.eigenvalues[i][i]);
                            for (int j = 0; j < 3; j++)
                                vec_reg[i][j] <= $signed(bus.eigenvectors[i][j]);
                        end
                        done_reg  <= 1'b0;
                        state_reg <= SELECT;
                    end
                end
                SELECT: begin
                    divisor_reg  <= abs_sum;
                    sum_zero_reg <= (sum_s == 18'sd0);
                    count_reg    <= '0;
                    for (int i = 0; i < 3; i++) begin
                        dividend_reg[i] <= {abs_v[i], 7'b0};
                        quot_reg[i]     <= '0;
                        rem_reg[i]      <= '0;
                        neg_reg[i]      <= vsel[i][15] ^ sum_s[17];
                    end
                    state_reg <= DIVIDE;
                end
                DIVIDE: begin
                    for (int i = 0; i < 3; i++) begin
                        dividend_reg[i] <= {dividend_reg[i][21:0], 1'b0};
                        quot_reg[i]     <= {quot_reg[i][21:0], fits[i]};
                        rem_reg[i]      <= rem_next[i];
                    end
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd22)
                        state_reg <= FINISH;
                end
                FINISH: begin
                    for (int i = 0; i < 3; i++)
                        port_reg[i] <= result_word[i];
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.done      = done_reg;
    assign bus.portfolio = port_reg;
endmodule

// File: tb/tb_eigenportfolio.sv
// Directed bench for eigenportfolio: timing of done, column selection, normalization, saturation, reset.
module tb_eigenportfolio;
    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;
    int   ec;

    eigenportfolio_if bus ();

    eigenportfolio dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2);
        check({tag, "_w0"}, bus.portfolio[0], e0);
        check({tag, "_w1"}, bus.portfolio[1], e1);
        check({tag, "_w2"}, bus.portfolio[2], e2);
        $display("%s: portfolio=%h %h %h done=%b", tag, bus.portfolio[0], bus.portfolio[1],
                 bus.portfolio[2], bus.done);
    endtask

    // Off-diagonal eigenvalues and non-selected columns carry distinctive filler.
    task automatic load(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                        input int k, input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2);
        logic [15:0] d [3];
        logic [15:0] v [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        v[0] = v0; v[1] = v1; v[2] = v2;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                bus.eigenvalues[r][c]  = (r == c) ? d[r] : 16'h7777;
                bus.eigenvectors[r][c] = (c == k) ? v[r] : 16'h0100;
            end
    endtask

    // Pulse start so it is sampled at the next rising edge (E0), then scramble the inputs.
    task automatic launch();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ec = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                bus.eigenvalues[r][c]  = 16'($urandom);
                bus.eigenvectors[r][c] = 16'($urandom);
            end
    endtask

    task automatic wait_to(input int n);
        repeat (n - ec) @(posedge clk);
        #1;
        ec = n;
    endtask

    task automatic finish_run(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2);
        wait_to(24);
        check({tag, "_done_e24"}, {15'b0, bus.done}, 16'd0);
        wait_to(25);
        check({tag, "_done_e25"}, {15'b0, bus.done}, 16'd1);
        check_port(tag, e0, e1, e2);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        ec           = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.eigenvalues  = '0;
        bus.eigenvectors = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {15'b0, bus.done}, 16'd0);
        check_port("reset", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Middle of (3,4,1) is column 0: 1.25,3.5,5.25 over 10.0.
        load(16'h0300, 16'h0400, 16'h0100, 0, 16'h0140, 16'h0380, 16'h0540);
        launch();
        check("runA_done_e0", {15'b0, bus.done}, 16'd0);
        finish_run("runA", 16'h0020, 16'h0058, 16'h0086);

        // Back-to-back: done falls at the accepting edge while portfolio holds.
        load(16'h0300, 16'h0400, 16'h0A00, 1, 16'h0140, 16'hFC80, 16'h0540);
        launch();
        check("runB_done_drop", {15'b0, bus.done}, 16'd0);
        check_port("runB_hold", 16'h0020, 16'h0058, 16'h0086);
        finish_run("runB", 16'h006A, 16'hFED6, 16'h01C0);

        // Selected column sums to zero.
        load(16'h0100, 16'h0200, 16'h0300, 1, 16'h0100, 16'hFF00, 16'h0000);
        launch();
        finish_run("sum0", 16'h0000, 16'h0000, 16'h0000);

        // |S| = 1 LSB: first two components saturate, third is 0x0100.
        load(16'h0200, 16'h0100, 16'h0300, 0, 16'h0100, 16'hFF00, 16'h0001);
        launch();
        finish_run("sat", 16'h7FFE, 16'h8002, 16'h0100);

        // Signed ranking (-1,2,1) -> column 2; negative sum.
        load(16'hFF00, 16'h0200, 16'h0100, 2, 16'hFE00, 16'hFF00, 16'h0000);
        launch();
        finish_run("negdiag", 16'h00AA, 16'h0054, 16'h0000);

        // Tie (5,5,1): index 1 is the middle.
        load(16'h0500, 16'h0500, 16'h0100, 1, 16'h0140, 16'h0380, 16'h0540);
        launch();
        finish_run("tie", 16'h0020, 16'h0058, 16'h0086);

        // A start during the run is ignored.
        load(16'h0300, 16'h0400, 16'h0100, 0, 16'h0140, 16'h0380, 16'h0540);
        launch();
        wait_to(4);
        bus.start = 1'b1;
        wait_to(5);
        bus.start = 1'b0;
        finish_run("ignore", 16'h0020, 16'h0058, 16'h0086);
        wait_to(30);
        check("ignore_done_hold", {15'b0, bus.done}, 16'd1);
        check_port("ignore_hold", 16'h0020, 16'h0058, 16'h0086);

        // Reset mid-division, then a fresh run.
        load(16'h0300, 16'h0400, 16'h0A00, 1, 16'h0140, 16'hFC80, 16'h0540);
        launch();
        wait_to(10);
        rst = 1'b1;
        #1;
        check("rst_mid_done", {15'b0, bus.done}, 16'd0);
        check_port("rst_mid", 16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        load(16'h0300, 16'h0400, 16'h0A00, 1, 16'h0140, 16'hFC80, 16'h0540);
        launch();
        finish_run("after_rst", 16'h006A, 16'hFED6, 16'h01C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/eigenportfolio.md
EIGENPORTFOLIO -- requirements
Module: eigenportfolio

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request; sampled on rising clk.
REQ-005 eigenvalues  input  signed [2:0][2:0][15:0]  Q8.8 matrix; only diagonal [c][c] used, off-diagonal ignored.
REQ-006 eigenvectors  input  signed [2:0][2:0][15:0]  Q8.8; column c (elements [r][c], r=0..2) is the eigenvector of eigenvalues[c][c].
REQ-007 done  output  1  result valid level.
REQ-008 portfolio  output  signed [2:0][15:0]  Q8.8 normalized weights, registered.

Function
REQ-009 The block SHALL capture eigenvalue diagonal and eigenvectors into internal registers on the edge where start=1 in IDLE; inputs may change afterward.
REQ-010 The block SHALL select column k whose eigenvalue is the middle one (second-largest) of the three diagonal values, compared as signed; ties ranked with lower index first.
REQ-011 The block SHALL compute S = v0+v1+v2 (v_r = eigenvectors[r][k]) at 18-bit signed width, no overflow.
REQ-012 For each r, the block SHALL compute q_r = floor(|v_r|*128 / |S|) (unsigned restoring division, 23-bit dividend, 17-bit divisor) and portfolio[r] = sign * (q_r*2), sign negative iff sign(v_r) XOR sign(S); result truncates toward zero at 7 fractional bits, LSB always 0.
REQ-013 Magnitudes exceeding 16'sh7FFE SHALL saturate to +16'sh7FFE / -16'sh7FFE.
REQ-014 If S==0, all portfolio words SHALL be 0 and done SHALL assert at normal latency.
REQ-015 FSM states: IDLE -> SELECT (1 cycle: column choice, sum) -> DIVIDE (23 cycles, three dividers in parallel, 1 quotient bit/cycle) -> FINISH (register outputs, done=1) -> IDLE.
REQ-016 Latency: with start sampled at edge E0, portfolio and done SHALL update at edge E25.
REQ-017 done SHALL clear on the edge start is accepted and stay high from completion until the next accepted start; portfolio SHALL hold its value until the next completion.
REQ-018 start while not IDLE (SELECT/DIVIDE/FINISH) SHALL be ignored.
REQ-019 Implementation size target: 120-400 lines RTL.

Reset
REQ-020 Asserting rst at any time, including mid-division, SHALL immediately force IDLE, done=0, all portfolio words 0, and clear internal registers.
REQ-021 After rst deasserts, the block SHALL accept start on the next rising edge.

Verification
REQ-022 diag(3,4,1); column 0 = 0x0140,0x0380,0x0540 (1.25,3.5,5.25); start pulse -> done at E25, portfolio = 32, 88, 134.
REQ-023 Back-to-back second run, diag(3,4,10); column 1 = 0x0140,0xFC80,0x0540 (1.25,-3.5,5.25) -> done drops after start, then portfolio = 0x006A, 0xFED6, 0x01C0.
REQ-024 Selected column sums to 0 (e.g. 0x0100,0xFF00,0x0000) -> portfolio = 0,0,0, done asserted.
REQ-025 diag(5,5,1), distinct columns -> column 1 selected (tie, lower index ranks first; middle = index 1).
REQ-026 rst pulsed at E10 of a run -> done=0, portfolio=0 immediately; new start then completes normally.
REQ-027 Second start pulse at E5 of a run -> ignored; completion still at E25 with first run's result.
